// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions: S-box table, xtime, round constant.
// Helpers: total_words(nr) gives the schedule length 4*(nr+1).
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int total_words(input int nr);
    return 4 * (nr + 1);
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Key-expansion request/result bundle.
// master drives start/key; slave returns exp/busy/done.
interface key_expansion_if #(
  parameter int NK = 8,
  parameter int NR = 14
);
  logic                    start;
  logic [32*NK-1:0]        key;
  logic [128*(NR+1)-1:0]   exp;
  logic                    busy;
  logic                    done;

  modport master (
    output start, key,
    input  exp, busy, done
  );

  modport slave (
    input  start, key,
    output exp, busy, done
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box byte lookup.
// Ports: a_i byte in, y_o substituted byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  import aes_pkg::*;

  assign y_o = SBOX[a_i];
endmodule

// File: rtl/key_expansion.sv
// Iterative AES key schedule, one word per clock, Nk in {4,6,8}.
// Ports: clk, rst_n, bus (slave: start/key in; exp/busy/done out).
module key_expansion #(
  parameter int Nk = 8,
  parameter int Nr = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  key_expansion_if.slave bus
);
  import aes_pkg::*;

  localparam int T  = total_words(Nr);
  localparam int EW = 32 * T;
  localparam int KW = 32 * Nk;
  localparam int IW = $clog2(T + 1);
  localparam int AW = $clog2(EW);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] mod_q, mod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          done_q, done_d;

  logic [AW-1:0] prev_ix, back_ix, wr_ix;
  word_t         prev_w, back_w;
  word_t         sb_in, sb_out;
  word_t         temp_w, new_w;
  logic          rot_sel, sub_sel;

  // w[0] sits in the top word, so word j lives at bit 32*(T-1-j).
  always_comb begin
    prev_ix = '0;
    back_ix = '0;
    wr_ix   = '0;
    if (state_q == RUN) begin
      prev_ix = AW'(32 * (T - int'(idx_q)));
      back_ix = AW'(32 * (T - 1 - int'(idx_q) + Nk));
      wr_ix   = AW'(32 * (T - 1 - int'(idx_q)));
    end
  end

  assign prev_w = exp_q[prev_ix +: 32];
  assign back_w = exp_q[back_ix +: 32];

  assign rot_sel = (mod_q == '0);
  assign sub_sel = (Nk == 8) && (mod_q == IW'(4));

  assign sb_in = rot_sel ? {prev_w[23:0], prev_w[31:24]}
                         : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sb (
      .a_i (sb_in[8*b +: 8]),
      .y_o (sb_out[8*b +: 8])
    );
  end

  always_comb begin
    temp_w = prev_w;
    unique case (1'b1)
      rot_sel: temp_w = sb_out ^ {rcon_q, 24'h0};
      sub_sel: temp_w = sb_out;
      default: temp_w = prev_w;
    endcase
  end

  assign new_w = back_w ^ temp_w;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = RUN;
        exp_d   = {bus.key, {(EW-KW){1'b0}}};
        idx_d   = IW'(Nk);
        mod_d   = '0;
        rcon_d  = RCON_INIT;
      end
    end else begin
      exp_d[wr_ix +: 32] = new_w;
      idx_d = idx_q + 1'b1;
      mod_d = (mod_q == IW'(Nk - 1)) ? '0
                                     : mod_q + 1'b1;
      if (rot_sel) rcon_d = xtime(rcon_q);
      if (idx_q == IW'(T - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      idx_q   <= '0;
      mod_q   <= '0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign bus.exp  = exp_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: AES-128/192/256 instances, vector table,
// scoreboard queue, ignored-start, mid-run reset and back-to-back runs.
module tb_key_expansion;

  typedef struct packed {
    logic [1:0]   cfg;
    logic [255:0] key;
    logic [5:0]   i0;
    logic [31:0]  v0;
    logic [5:0]   i1;
    logic [31:0]  v1;
    logic [5:0]   i2;
    logic [31:0]  v2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_expansion_if #(.NK(4), .NR(10)) b4 ();
  key_expansion_if #(.NK(6), .NR(12)) b6 ();
  key_expansion_if #(.NK(8), .NR(14)) b8 ();

  key_expansion #(.Nk(4), .Nr(10)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));
  key_expansion #(.Nk(6), .Nr(12)) u6 (
    .clk(clk), .rst_n(rst_n), .bus(b6));
  key_expansion #(.Nk(8), .Nr(14)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));

  int   nvec = 0;
  int   nerr = 0;
  vec_t sb_q [$];
  vec_t vt [4];

  function automatic int nk(input logic [1:0] c);
    return 4 + 2 * int'(c);
  endfunction

  function automatic int tw(input logic [1:0] c);
    return 44 + 8 * int'(c);
  endfunction

  function automatic int gw(input logic [1:0] c);
    return tw(c) - nk(c);
  endfunction

  function automatic logic [31:0] wget(input logic [1:0] c,
                                       input int j);
    int s;
    s = 32 * (tw(c) - 1 - j);
    case (c)
      2'd0:    return 32'(b4.exp >> s);
      2'd1:    return 32'(b6.exp >> s);
      default: return 32'(b8.exp >> s);
    endcase
  endfunction

  function automatic logic dn(input logic [1:0] c);
    case (c)
      2'd0:    return b4.done;
      2'd1:    return b6.done;
      default: return b8.done;
    endcase
  endfunction

  function automatic logic bz(input logic [1:0] c);
    case (c)
      2'd0:    return b4.busy;
      2'd1:    return b6.busy;
      default: return b8.busy;
    endcase
  endfunction

  function automatic logic anyx(input logic [1:0] c);
    case (c)
      2'd0:    return |b4.exp;
      2'd1:    return |b6.exp;
      default: return |b8.exp;
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic set_in(input logic [1:0] c, input logic s,
                        input logic [255:0] k);
    case (c)
      2'd0:    begin b4.start = s; b4.key = k[255:128]; end
      2'd1:    begin b6.start = s; b6.key = k[255:64];  end
      default: begin b8.start = s; b8.key = k;          end
    endcase
  endtask

  task automatic start_run(input logic [1:0] c,
                           input logic [255:0] k);
    set_in(c, 1'b1, k);
    @(negedge clk);
    set_in(c, 1'b0, k);
  endtask

  task automatic wait_done(input logic [1:0] c, input int n0,
                           output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!dn(c) && n < 200);
  endtask

  task automatic retire(input logic [1:0] c, input int n);
    vec_t v;
    if (sb_q.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL sb_empty: got done, want no result");
      return;
    end
    v = sb_q.pop_front();
    check("latency", n, gw(c));
    check("done_hi", 32'(dn(c)), 32'd1);
    check("busy_at_done", 32'(bz(c)), 32'd0);
    for (int j = 0; j < nk(c); j++)
      check("key_word", wget(c, j),
            32'(v.key >> (32 * (7 - j))));
    check("w_a", wget(c, int'(v.i0)), v.v0);
    check("w_b", wget(c, int'(v.i1)), v.v1);
    check("w_last", wget(c, int'(v.i2)), v.v2);
  endtask

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
     64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    int n;
    int extra;
    logic [1:0] c;

    vt[0] = '{cfg: 2'd0, key: K128,
              i0: 6'd4,  v0: 32'ha0fafe17,
              i1: 6'd5,  v1: 32'h88542cb1,
              i2: 6'd43, v2: 32'hb6630ca6};
    vt[1] = '{cfg: 2'd1, key: K192,
              i0: 6'd6,  v0: 32'hfe0c91f7,
              i1: 6'd7,  v1: 32'h2402f5a5,
              i2: 6'd51, v2: 32'h01002202};
    vt[2] = '{cfg: 2'd2, key: K256,
              i0: 6'd8,  v0: 32'h9ba35411,
              i1: 6'd9,  v1: 32'h8e6925af,
              i2: 6'd59, v2: 32'h706c631e};
    vt[3] = '{cfg: 2'd0, key: 256'h0,
              i0: 6'd4,  v0: 32'h62636363,
              i1: 6'd8,  v1: 32'h9b9898c9,
              i2: 6'd43, v2: 32'h6f8f188e};

    rst_n = 1'b0;
    for (int q = 0; q < 3; q++) set_in(2'(q), 1'b0, 256'h0);
    repeat (3) @(negedge clk);
    for (int q = 0; q < 3; q++) begin
      check("rst_exp", 32'(anyx(2'(q))), 32'd0);
      check("rst_busy", 32'(bz(2'(q))), 32'd0);
      check("rst_done", 32'(dn(2'(q))), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      c = vt[t].cfg;
      sb_q.push_back(vt[t]);
      start_run(c, vt[t].key);
      check("busy_after_start", 32'(bz(c)), 32'd1);
      check("tail_zero", wget(c, tw(c) - 1), 32'd0);
      wait_done(c, 0, n);
      retire(c, n);
      @(negedge clk);
      check("done_pulse", 32'(dn(c)), 32'd0);
    end

    // second start while busy carries a different key
    sb_q.push_back(vt[2]);
    start_run(2'd2, K256);
    repeat (4) @(negedge clk);
    set_in(2'd2, 1'b1, 256'h0);
    @(negedge clk);
    set_in(2'd2, 1'b0, 256'h0);
    wait_done(2'd2, 5, n);
    retire(2'd2, n);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (dn(2'd2)) extra++;
    end
    check("single_done", extra, 0);
    check("idle_after", 32'(bz(2'd2)), 32'd0);

    // reset in the middle of an AES-192 run
    start_run(2'd1, K192);
    repeat (19) @(negedge clk);
    check("midrun_busy", 32'(bz(2'd1)), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_exp", 32'(anyx(2'd1)), 32'd0);
    check("abort_busy", 32'(bz(2'd1)), 32'd0);
    check("abort_done", 32'(dn(2'd1)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_q.push_back(vt[1]);
    start_run(2'd1, K192);
    wait_done(2'd1, 0, n);
    retire(2'd1, n);

    // back-to-back: restart in the done cycle
    @(negedge clk);
    sb_q.push_back(vt[0]);
    start_run(2'd0, vt[0].key);
    wait_done(2'd0, 0, n);
    retire(2'd0, n);
    sb_q.push_back(vt[3]);
    start_run(2'd0, vt[3].key);
    check("b2b_busy", 32'(bz(2'd0)), 32'd1);
    wait_done(2'd0, 0, n);
    retire(2'd0, n);

    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
# key_expansion

Iterative AES key schedule (FIPS-197 KeyExpansion) for AES-128/192/256. It accepts a cipher key of Nk 32-bit words and produces all 4·(Nr+1) round-key words packed into a single wide register. It computes one word per clock and sits between key loading and the round datapath of the AES core.

## Interface
- Nk, default 8: key length in 32-bit words. Legal values are 4, 6 and 8.
- Nr, default 14: number of rounds. Legal pairs are (4,10), (6,12) and (8,14). Other combinations are unsupported.
- clk  input  1  the single clock; everything is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to expand `key`.
- key  input  32·Nk  cipher key. Bits [0:31] (leftmost hex) are w[0]; the last 32 bits are w[Nk-1].
- exp  output  128·(Nr+1)  expanded schedule. w[0] occupies the most-significant 32 bits and w[4·(Nr+1)-1] the least-significant. Printed in hex, exp begins with the key.
- busy  output  1  high while words are being generated.
- done  output  1  one-cycle pulse when exp is complete and valid.

## Operation
- Total words: T = 4·(Nr+1), i.e. 44, 52 or 60.
- Generated words: G = T − Nk, i.e. 40, 46 or 52.
- start while idle:
  - Load w[0..Nk-1] from `key` into exp.
  - Clear the remaining words to 0.
  - Set index i = Nk and rcon = 8'h01.
  - Assert busy.
- Each busy cycle computes w[i] = w[i−Nk] XOR temp, where temp = w[i−1] and:
  - if i mod Nk == 0: temp = SubWord(RotWord(temp)) XOR {rcon, 24'h0}. rcon then advances by xtime (·2 in GF(2^8), poly 0x11B), giving the sequence 01,02,04,08,10,20,40,80,1b,36.
  - else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
  - otherwise temp is unchanged.
- RotWord: [a0,a1,a2,a3] → [a1,a2,a3,a0]. SubWord applies the AES S-box to each byte.
- Write w[i] into exp, then i ← i+1. Track i mod Nk with a wrapping counter; no divider.
- After w[T−1] is written: pulse done for one cycle, clear busy, and hold exp until the next start or reset.
- start while busy is ignored. `key` is sampled only on the accepted start cycle.
- While busy, exp holds the completed words plus zeros. Consumers use exp only after done.

## Timing
- Reset (async assert, sync release) clears exp, busy, done, i and the mod-Nk counter to 0, and rcon to 8'h01.
- Reset mid-expansion aborts the run; exp returns to 0 and no done pulse is produced.
- Start accepted on edge k: busy=1 from k, key words visible in exp from k.
- w[Nk] is written on edge k+1, w[T−1] on edge k+G.
- done=1 and busy=0 are registered on edge k+G. exp is valid from that edge.
- Latency from start to done: G cycles (40/46/52).
- start in the same cycle done is high is accepted, enabling back-to-back runs.
- The S-box path is combinational within one cycle: four byte look-ups plus XOR.

## Structure
- Package `aes_pkg`:
  - 256-entry S-box constant table.
  - xtime function.
  - RCON_INIT constant.
  - Helpers for word count T(Nk,Nr).
- Sub-module `aes_sbox`: combinational byte-in/byte-out S-box, instantiated 4 times for SubWord.
- key_expansion holds the FSM (IDLE, RUN), index and mod-Nk counters, rcon register and the exp register.

## Test plan
- Nk=4, Nr=10, key 2b7e1516_28aed2a6_abf71588_09cf4f3c → after 40 cycles done pulses; w4=a0fafe17, w5=88542cb1, w43=b6630ca6.
- Nk=6, Nr=12, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b → after 46 cycles w6=fe0c91f7, w7=2402f5a5, w51=01002202.
- Nk=8, Nr=14, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 → after 52 cycles w8=9ba35411, w9=8e6925af, w59=706c631e; exp top 256 bits equal the key.
- Second start asserted while busy, with a different key → ignored; result matches the first key; single done pulse.
- rst_n pulled low at cycle 20 of a run → exp, busy, done go to 0 immediately; a new start gives the correct full schedule.
- Start asserted in the done cycle with a new key → second run completes G cycles later with the correct second schedule.
